// File: rtl/countdown_pkg.sv
// Shared types and constants for the single-digit countdown timer and its
// 7-segment display path.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] SEG_MAX = 4'd9;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_PAT_0     = 7'b1000000;
  localparam logic [6:0] SEG_PAT_1     = 7'b1111001;
  localparam logic [6:0] SEG_PAT_2     = 7'b0100100;
  localparam logic [6:0] SEG_PAT_3     = 7'b0110000;
  localparam logic [6:0] SEG_PAT_4     = 7'b0011001;
  localparam logic [6:0] SEG_PAT_5     = 7'b0010010;
  localparam logic [6:0] SEG_PAT_6     = 7'b0000010;
  localparam logic [6:0] SEG_PAT_7     = 7'b1111000;
  localparam logic [6:0] SEG_PAT_8     = 7'b0000000;
  localparam logic [6:0] SEG_PAT_9     = 7'b0010000;
  localparam logic [6:0] SEG_PAT_BLANK = 7'b1111111;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value);
    return (value > SEG_MAX) ? SEG_MAX : value;
  endfunction

endpackage

// File: rtl/countdown10s_seg7_decode.sv
// Binary digit to active-low 7-segment decoder; anything above 9 shows blank.
module seg7_decode
  import countdown_pkg::*;
(
  input  logic [3:0] bin_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_PAT_BLANK;
    case (bin_i)
      4'd0:    seg_n_o = SEG_PAT_0;
      4'd1:    seg_n_o = SEG_PAT_1;
      4'd2:    seg_n_o = SEG_PAT_2;
      4'd3:    seg_n_o = SEG_PAT_3;
      4'd4:    seg_n_o = SEG_PAT_4;
      4'd5:    seg_n_o = SEG_PAT_5;
      4'd6:    seg_n_o = SEG_PAT_6;
      4'd7:    seg_n_o = SEG_PAT_7;
      4'd8:    seg_n_o = SEG_PAT_8;
      4'd9:    seg_n_o = SEG_PAT_9;
      default: seg_n_o = SEG_PAT_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown10s.sv
// Single-digit countdown timer: preset load, run/pause on ctrl rising edges,
// one decrement per TICK_DIV running clocks, one-cycle done pulse at zero.
module countdown10s
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl,
  input  logic       load,
  input  logic [3:0] preset,
  output logic [3:0] seg,
  output logic [6:0] hex,
  output logic       running,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Handshake: none; ctrl is a level, load is a single-cycle strobe sampled on
  // every rising edge, outputs are valid continuously.
  state_e          state_q, state_d;
  logic [3:0]      seg_q, seg_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q;
  logic            done_q, done_d;
  logic            ctrl_q;
  logic            start_ev;
  logic            tick;

  assign start_ev = ctrl & ~ctrl_q;
  assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (state_q == ST_RUN) begin
      // The prescaler advances on every RUN cycle, including the pause edge,
      // so a resumed step finishes exactly where it left off.
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && (seg_q != 4'd0)) begin
        seg_d = seg_q - 4'd1;
        if (seg_q == 4'd1) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end else if (start_ev) begin
          state_d = ST_PAUSE;
        end
      end else if (start_ev) begin
        state_d = ST_PAUSE;
      end
    end else if (load) begin
      seg_d   = clamp_digit(preset);
      presc_d = '0;
      state_d = ST_IDLE;
    end else if (start_ev) begin
      case (state_q)
        ST_IDLE: begin
          if (seg_q != 4'd0) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seg_q     <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      ctrl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      presc_q   <= presc_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= done_d;
      ctrl_q    <= ctrl;
    end
  end

  seg7_decode u_decode (
    .bin_i   (seg_q),
    .seg_n_o (hex)
  );

  assign seg       = seg_q;
  assign running   = running_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/countdown10s.md
# countdown10s

Single-digit countdown timer, the reverse-direction counterpart of the team's 0–9 stopwatch. Loads a preset (0–9), counts down once per `TICK_DIV` clocks while running, and flags expiry at zero. A rising edge on `ctrl` starts and pauses the count. Sits between a debounced push-button/switch front end and the board's 7-segment display.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count step; legal range ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ctrl`  in  1  level input; each rising edge (0→1 between samples) toggles run/pause.
- `load`  in  1  synchronous load strobe for `preset`.
- `preset`  in  4  start value; values > 9 clamp to 9.
- `seg`  out  4  current count, binary 0–9 (registered).
- `hex`  out  7  active-low segments {g,f,e,d,c,b,a}, combinational decode of `seg`.
- `running`  out  1  high while in RUN (registered).
- `done`  out  1  one-cycle pulse when the count reaches 0 (registered).

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: state=IDLE, `seg`=0, `hex`=7'b1000000, `running`=0, `done`=0, prescaler=0, `ctrl_q`=0.
- Edge detect: `ctrl_q` registers `ctrl` every cycle; `start_ev` = `ctrl & ~ctrl_q`.
- `load` in IDLE, PAUSE or EXPIRED sets `seg` ← min(`preset`, 9), clears the prescaler, and goes to IDLE. `load` in RUN is ignored.
- If `load` and `start_ev` occur in the same cycle outside RUN, `load` wins and `start_ev` is dropped.
- `start_ev` transitions:
  - IDLE with `seg` ≠ 0 → RUN; prescaler cleared.
  - IDLE with `seg` = 0 → stays IDLE.
  - RUN → PAUSE; prescaler holds its value.
  - PAUSE → RUN; prescaler resumes.
  - EXPIRED → ignored. Only `load` leaves EXPIRED.
- In RUN the prescaler counts 0..`TICK_DIV`-1 and wraps. On reaching `TICK_DIV`-1 a tick fires and `seg` decrements.
  - If the tick takes `seg` from 1 to 0: state → EXPIRED and `done`=1 for exactly that one cycle.
- Tick and `start_ev` in the same RUN cycle: the decrement is applied and state → PAUSE. If that decrement reaches 0, EXPIRED wins over PAUSE.
- `seg` never wraps below 0 and never exceeds 9.
- `running` = 1 iff the next state is RUN, registered alongside the state.
- Prescaler width = $clog2(`TICK_DIV`).

## Timing
- `start_ev` is acted on at the first clock edge where `ctrl`=1 is sampled with `ctrl_q`=0. `running` rises at that same edge.
- First decrement occurs exactly `TICK_DIV` cycles after entry to RUN from IDLE.
- After a pause, the remaining portion of the interrupted step is preserved.
- Preset N reaches 0 after N·`TICK_DIV` RUN cycles. `done` and `seg`=0 appear at the same edge.
- `load` takes effect at the next edge; `hex` follows `seg` combinationally, with no extra cycle.
- Asserting `rst` mid-count forces all outputs to their reset values immediately (asynchronous). Deassertion is synchronized externally.

## Structure
- Package `countdown_pkg`:
  - state encoding (2-bit IDLE=0, RUN=1, PAUSE=2, EXPIRED=3);
  - `SEG_MAX`=9;
  - 7-segment pattern constants for digits 0–9 plus blank.
- Sub-module `seg7_decode`: 4-bit binary → 7-bit active-low segments. Inputs > 9 produce blank (7'b1111111). It is shared with the stopwatch display path.
- Top level holds the FSM, the prescaler and the edge detector.

## Test plan
Run all scenarios with `TICK_DIV`=4.
- Reset check: assert `rst` → `seg`=0, `hex`=7'b1000000, `running`=0, `done`=0; hold `ctrl` high during release → no start until `ctrl` goes 0 then 1.
- Full countdown: load 3, pulse `ctrl` → `seg` 3→2→1→0 at 4, 8, 12 cycles after the start edge; `done`=1 for one cycle at cycle 12; state EXPIRED; further `ctrl` edges leave `seg`=0.
- Pause/resume: load 5, start, pause 2 cycles after the start edge, wait 20 cycles with `seg` still 5, resume → `seg`=4 two cycles later.
- Clamp and guards: load 12 → `seg`=9; `load` 7 during RUN ignored; start with `seg`=0 stays IDLE, `running`=0.
- Simultaneous events: at `seg`=1, `start_ev` on the tick cycle → `seg`=0, EXPIRED, `done` pulse; at `seg`=4, same case → `seg`=3, PAUSE.
- Async reset mid-run: load 6, start, assert `rst` between clock edges at `seg`=4 → outputs at reset values before the next edge.
